// File: rtl/vram_dump_tx.sv
// vram_dump_tx: streams the text VRAM out of a UART TX line as 8N1 ASCII,
// one row at a time, each row followed by CR+LF.
// Optional build macro VRAM_DUMP_SANITIZE_EN: non-printable VRAM bytes
// (outside 0x20..0x7E) are sent as a space; CR/LF are never altered.
module vram_dump_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIRST_COL    = 0,
  parameter int LAST_COL     = 59,
  parameter int FIRST_ROW    = 0,
  parameter int LAST_ROW     = 16,
  parameter int VRAM_RD_LAT  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_running,
  output logic        o_done,
  output logic [10:0] o_vram_addr,
  output logic        o_vram_ce,
  output logic        o_vram_w,
  input  logic [7:0]  i_vram_dout,
  output logic        o_uart_tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        ROW_F     = 5'(FIRST_ROW);
  localparam logic [4:0]        ROW_L     = 5'(LAST_ROW);
  localparam logic [5:0]        COL_F     = 6'(FIRST_COL);
  localparam logic [5:0]        COL_L     = 6'(LAST_COL);
  localparam logic [1:0]        WAIT_LAST = 2'(VRAM_RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_SEND, S_EOL_CR, S_EOL_LF, S_DONE
  } state_t;

  state_t            r_state;
  logic [4:0]        r_row;
  logic [5:0]        r_col;
  logic [10:0]       r_addr;
  logic              r_ce;
  logic              r_running;
  logic              r_done;
  logic              r_tx;
  logic [7:0]        r_sh;
  logic [3:0]        r_bit;
  logic [BAUD_W-1:0] r_baud;
  logic [1:0]        r_wcnt;

  logic [7:0]        w_tx_byte;
  logic              w_bit_end;

`ifdef VRAM_DUMP_SANITIZE_EN
  // Cleared cells hold 0x00; map anything non-printable to a space.
  assign w_tx_byte = (i_vram_dout < 8'h20 || i_vram_dout > 8'h7E) ? 8'h20 : i_vram_dout;
`else
  assign w_tx_byte = i_vram_dout;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Dump sequencer: address walk, VRAM read, and 8N1 shifter in one FSM.
  // The shift register refills with 1s so the stop bit falls out naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_addr    <= '0;
      r_ce      <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_tx      <= 1'b1;
      r_sh      <= 8'hFF;
      r_bit     <= '0;
      r_baud    <= '0;
      r_wcnt    <= '0;
    end else begin
      r_ce   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_row     <= ROW_F;
          r_col     <= COL_F;
          r_addr    <= {ROW_F, COL_F};
          r_ce      <= 1'b1;
          r_running <= 1'b1;
          r_state   <= S_RD;
        end
        S_RD: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt == WAIT_LAST) begin
            r_sh    <= w_tx_byte;
            r_tx    <= 1'b0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_state <= S_SEND;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        S_SEND, S_EOL_CR, S_EOL_LF: begin
          if (!w_bit_end) begin
            r_baud <= r_baud + 1'b1;
          end else begin
            r_baud <= '0;
            if (r_bit != 4'd9) begin
              r_bit <= r_bit + 4'd1;
              r_tx  <= r_sh[0];
              r_sh  <= {1'b1, r_sh[7:1]};
            end else if (r_state == S_SEND && r_col != COL_L) begin
              r_col   <= r_col + 6'd1;
              r_addr  <= {r_row, r_col + 6'd1};
              r_ce    <= 1'b1;
              r_state <= S_RD;
            end else if (r_state == S_SEND) begin
              r_sh    <= 8'h0D;
              r_tx    <= 1'b0;
              r_bit   <= '0;
              r_state <= S_EOL_CR;
            end else if (r_state == S_EOL_CR) begin
              r_sh    <= 8'h0A;
              r_tx    <= 1'b0;
              r_bit   <= '0;
              r_state <= S_EOL_LF;
            end else if (r_row != ROW_L) begin
              r_row   <= r_row + 5'd1;
              r_col   <= COL_F;
              r_addr  <= {r_row + 5'd1, COL_F};
              r_ce    <= 1'b1;
              r_state <= S_RD;
            end else begin
              r_done    <= 1'b1;
              r_running <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_vram_addr = r_addr;
  assign o_vram_ce   = r_ce;
  assign o_vram_w    = 1'b0;
  assign o_uart_tx   = r_tx;

endmodule

// File: tb/tb_vram_dump_tx.sv
// tb_vram_dump_tx: directed bench for vram_dump_tx on a reduced screen
// (3 rows x 4 cols, 8 clocks per bit) so full dumps stay short.
module tb_vram_dump_tx;
  localparam int CPB = 8;
  localparam int LC  = 3;
  localparam int LR  = 2;
  localparam int NFR = (LR + 1) * (LC + 1 + 2);

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        running, done, ce, vw, tx;
  logic [10:0] addr;
  logic [7:0]  dout = 0;

  logic [7:0]  mem     [0:2047];
  logic [7:0]  exp_mem [0:2047];
  logic [7:0]  rx_q[$];
  time         rx_t[$];
  logic [10:0] ce_q[$];
  logic [7:0]  expq[$];
  int checks = 0, errors = 0;
  int ce_cnt = 0, done_cnt = 0, viol = 0, frame_err = 0;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] data;
    logic [7:0] exp_raw;
    logic [7:0] exp_san;
  } vec_t;
  vec_t tbl[10];

  vram_dump_tx #(.CLKS_PER_BIT(CPB), .FIRST_COL(0), .LAST_COL(LC),
                 .FIRST_ROW(0), .LAST_ROW(LR), .VRAM_RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_running(running),
    .o_done(done), .o_vram_addr(addr), .o_vram_ce(ce), .o_vram_w(vw),
    .i_vram_dout(dout), .o_uart_tx(tx));

  always #5 clk = ~clk;

  // One-cycle-latency VRAM model.
  always @(posedge clk) if (ce) dout <= mem[addr];

  // Protocol monitors sampled on the falling edge.
  logic prev_ce = 0, prev_run = 0;
  always @(negedge clk) begin
    if (ce) begin ce_cnt++; ce_q.push_back(addr); end
    if (ce && prev_ce) viol++;
    if (vw !== 1'b0) viol++;
    if (done) begin
      done_cnt++;
      if (running || !prev_run) viol++;
    end
    prev_ce  = ce;
    prev_run = running;
  end

  // UART receiver: samples mid-bit, logs byte and start time.
  initial begin
    logic [7:0] d;
    time t0;
    forever begin
      @(negedge tx);
      t0 = $time;
      #(CPB * 5);
      if (tx !== 1'b0) frame_err++;
      for (int b = 0; b < 8; b++) begin #(CPB * 10); d[b] = tx; end
      #(CPB * 10);
      if (tx !== 1'b1) frame_err++;
      rx_q.push_back(d);
      rx_t.push_back(t0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic clear_q();
    rx_q.delete(); rx_t.delete(); ce_q.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_ce(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (ce_q.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (tx === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  function automatic void build_exp();
    expq.delete();
    for (int r = 0; r <= LR; r++) begin
      for (int c = 0; c <= LC; c++) expq.push_back(exp_mem[r * 64 + c]);
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endfunction

  task automatic check_dump(input string tag);
    chk({tag, "_frames"}, rx_q.size(), NFR);
    if (rx_q.size() == NFR)
      for (int i = 0; i < NFR; i++) chk($sformatf("%s_frame%0d", tag, i), rx_q[i], expq[i]);
    chk({tag, "_ce_count"}, ce_q.size(), (LR + 1) * (LC + 1));
    if (ce_q.size() == (LR + 1) * (LC + 1))
      for (int r = 0; r <= LR; r++)
        for (int c = 0; c <= LC; c++)
          chk($sformatf("%s_ce_addr_r%0d_c%0d", tag, r, c), ce_q[r * (LC + 1) + c], r * 64 + c);
  endtask

  initial begin
    bit ok;
    int n, bad, d0;
    int exp_dt[7];

    tbl[0] = '{0, 0, 8'h41, 8'h41, 8'h41};
    tbl[1] = '{0, 1, 8'h42, 8'h42, 8'h42};
    tbl[2] = '{0, 2, 8'h00, 8'h00, 8'h20};
    tbl[3] = '{0, 3, 8'h7F, 8'h7F, 8'h20};
    tbl[4] = '{1, 0, 8'h1F, 8'h1F, 8'h20};
    tbl[5] = '{1, 1, 8'h20, 8'h20, 8'h20};
    tbl[6] = '{1, 2, 8'h7E, 8'h7E, 8'h7E};
    tbl[7] = '{1, 3, 8'h80, 8'h80, 8'h20};
    tbl[8] = '{2, 0, 8'hFF, 8'hFF, 8'h20};
    tbl[9] = '{2, 1, 8'h0D, 8'h0D, 8'h20};
    exp_dt = '{0, 82, 82, 82, 80, 80, 82};

    for (int i = 0; i < 2048; i++) begin mem[i] = 8'h58; exp_mem[i] = 8'h58; end
    for (int i = 0; i < 10; i++) begin
      mem[tbl[i].row * 64 + tbl[i].col] = tbl[i].data;
`ifdef VRAM_DUMP_SANITIZE_EN
      exp_mem[tbl[i].row * 64 + tbl[i].col] = tbl[i].exp_san;
`else
      exp_mem[tbl[i].row * 64 + tbl[i].col] = tbl[i].exp_raw;
`endif
    end

    // Reset and idle.
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_addr", addr, 0);
    rst_n = 1;
    bad = 0;
    repeat (200) begin @(negedge clk); if (tx !== 1'b1 || running !== 1'b0) bad++; end
    chk("idle_line_high", bad, 0);
    chk("idle_no_ce", ce_cnt, 0);
    chk("idle_no_done", done_cnt, 0);

    // Dump 1: table contents, first-frame timing, frame spacing.
    clear_q(); build_exp();
    pulse_start();
    chk("d1_running", running, 1);
    wait_ce(1, 20, ok);
    chk("d1_first_ce_seen", ok, 1);
    if (ok) chk("d1_first_ce_addr", ce_q[0], 0);
    wait_tx_low(20, ok);
    chk("d1_start_bit_seen", ok, 1);
    n = 0;
    while (tx === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    chk("d1_start_bit_len", n, CPB);
    d0 = done_cnt;
    wait_done(5000, ok);
    chk("d1_done_seen", ok, 1);
    repeat (CPB * 12) @(negedge clk);
    check_dump("d1");
    chk("d1_done_once", done_cnt - d0, 1);
    chk("d1_running_low", running, 0);
    if (rx_t.size() >= 7)
      for (int i = 1; i < 7; i++)
        chk($sformatf("d1_spacing%0d", i), 32'((rx_t[i] - rx_t[i - 1]) / 10), exp_dt[i]);

    // Dump 2: all 0x58, with a stray i_start in row 1 that must be ignored.
    for (int i = 0; i < 2048; i++) begin mem[i] = 8'h58; exp_mem[i] = 8'h58; end
    clear_q(); build_exp();
    d0 = done_cnt;
    pulse_start();
    wait_ce(5, 1000, ok);
    chk("d2_row1_reached", ok, 1);
    pulse_start();
    wait_done(5000, ok);
    chk("d2_done_seen", ok, 1);
    repeat (CPB * 12) @(negedge clk);
    check_dump("d2");
    chk("d2_done_once", done_cnt - d0, 1);

    // Reset in the middle of a frame, then a fresh dump.
    clear_q();
    pulse_start();
    wait_tx_low(20, ok);
    chk("d3_start_bit_seen", ok, 1);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("rst_tx_async", tx, 1);
    chk("rst_running", running, 0);
    chk("rst_ce", ce, 0);
    chk("rst_addr", addr, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (CPB * 15) begin @(negedge clk); if (tx !== 1'b1 || running !== 1'b0) bad++; end
    chk("rst_no_partial_frame", bad, 0);
    clear_q(); build_exp();
    pulse_start();
    wait_ce(1, 20, ok);
    chk("d4_first_ce_seen", ok, 1);
    if (ok) chk("d4_first_ce_addr", ce_q[0], 0);
    wait_done(5000, ok);
    chk("d4_done_seen", ok, 1);
    repeat (CPB * 12) @(negedge clk);
    chk("d4_frames", rx_q.size(), NFR);

    chk("protocol_violations", viol, 0);
    chk("framing_errors", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
